ddrio_align_ctrl: RTL and testbench



---
 rtl/ddrio_align_pkg.sv | 35 +++
 rtl/ddrio_align_ctrl_if.sv | 32 +++
 rtl/ddrio_word_cmp.sv | 66 ++++++
 rtl/ddrio_align_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ddrio_align_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ddrio_align_pkg.sv
// Shared types and default timing for the ddrio_x2 DQ-pair training sequencer.
// Optional feature macro used by this slice: DDRIO_ALIGN_ERRCNT_EN (mismatch counter).
package ddrio_align_pkg;

    localparam int unsigned DEF_SETTLE_CYC = 16;
    localparam int unsigned DEF_PULSE_CYC  = 2;
    localparam int unsigned DEF_WAIT_CYC   = 8;
    localparam int unsigned DEF_MATCH_CYC  = 4;
    localparam int unsigned DEF_CMP_WIN    = 16;
    localparam int unsigned DEF_MAX_SLIP   = 8;

    // Timer must hold the longest timed state minus one; match counter up to CMP_WIN.
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned MCNT_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SETTLE     = 4'd1,
        ST_OL_PULSE   = 4'd2,
        ST_OL_WAIT    = 4'd3,
        ST_CMP        = 4'd4,
        ST_SLIP_PULSE = 4'd5,
        ST_SLIP_WAIT  = 4'd6,
        ST_DONE       = 4'd7,
        ST_FAIL       = 4'd8
    } align_state_e;

    // Both lanes must carry the training word for a cycle to count as a match.
    function automatic logic word_match(input logic [7:0] q_0,
                                        input logic [7:0] q_1,
                                        input logic [7:0] pattern);
        return (q_0 == pattern) && (q_1 == pattern);
    endfunction

endpackage

// File: rtl/ddrio_align_ctrl_if.sv
// Control/data bundle between the PHY init side and the training sequencer.
// With DDRIO_ALIGN_ERRCNT_EN defined the bundle also carries err_cnt.
interface ddrio_align_ctrl_if
    import ddrio_align_pkg::*;
#(
    parameter int unsigned SLIP_W = $clog2(DEF_MAX_SLIP)
) ();
    logic              start;
    logic [7:0]        pattern;
    logic [7:0]        q_0;
    logic [7:0]        q_1;
    logic              cken;
    logic              align_ol;
    logic              align_il;
    logic              busy;
    logic              done;
    logic              fail;
    logic [SLIP_W-1:0] slip_cnt;
`ifdef DDRIO_ALIGN_ERRCNT_EN
    logic [7:0]        err_cnt;

    modport master (output start, pattern, q_0, q_1,
                    input  cken, align_ol, align_il, busy, done, fail, slip_cnt, err_cnt);
    modport slave  (input  start, pattern, q_0, q_1,
                    output cken, align_ol, align_il, busy, done, fail, slip_cnt, err_cnt);
`else
    modport master (output start, pattern, q_0, q_1,
                    input  cken, align_ol, align_il, busy, done, fail, slip_cnt);
    modport slave  (input  start, pattern, q_0, q_1,
                    output cken, align_ol, align_il, busy, done, fail, slip_cnt);
`endif
endinterface

// File: rtl/ddrio_word_cmp.sv
// Word comparator: counts consecutive matching cycles while enabled and flags
// lock on the cycle that completes the run. Optional mismatch counter under
// DDRIO_ALIGN_ERRCNT_EN.
module ddrio_word_cmp
    import ddrio_align_pkg::*;
#(
    parameter int unsigned MATCH_CYC = DEF_MATCH_CYC
) (
    input  logic       geclk_ol_buf_o,
    input  logic       align_rst_ol,
    input  logic       en,
`ifdef DDRIO_ALIGN_ERRCNT_EN
    input  logic       clr,
    output logic [7:0] err_cnt,
`endif
    input  logic [7:0] pattern,
    input  logic [7:0] q_0,
    input  logic [7:0] q_1,
    output logic       lock
);

    logic              match_s;
    logic [MCNT_W-1:0] match_cnt_r;

    assign match_s = word_match(q_0, q_1, pattern);

    // Lock is taken on the cycle whose match brings the run to MATCH_CYC.
    assign lock = en && match_s && (match_cnt_r >= MCNT_W'(MATCH_CYC - 32'd1));

    // Consecutive-match counter; zero outside CMP so every CMP entry starts fresh.
    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            match_cnt_r <= '0;
        end else if (!en) begin
            match_cnt_r <= '0;
        end else if (match_s) begin
            if (match_cnt_r != MCNT_W'(MATCH_CYC)) begin
                match_cnt_r <= match_cnt_r + MCNT_W'(1);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end else begin
            match_cnt_r <= '0;
        end
    end

`ifdef DDRIO_ALIGN_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of compare cycles without a match, cleared per run.
    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            err_cnt_r <= 8'd0;
        end else if (clr) begin
            err_cnt_r <= 8'd0;
        end else if (en && !match_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: rtl/ddrio_align_ctrl.sv
// Training sequencer for one ddrio_x2 DQ pair: settle, align_ol pulse, then
// compare / slip until the training word locks or all gear positions fail.
// DDRIO_ALIGN_ERRCNT_EN adds the err_cnt mismatch counter output.
module ddrio_align_ctrl
    import ddrio_align_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
    parameter int unsigned WAIT_CYC   = DEF_WAIT_CYC,
    parameter int unsigned MATCH_CYC  = DEF_MATCH_CYC,
    parameter int unsigned CMP_WIN    = DEF_CMP_WIN,
    parameter int unsigned MAX_SLIP   = DEF_MAX_SLIP
) (
    input  logic                 geclk_ol_buf_o,
    input  logic                 align_rst_ol,
    ddrio_align_ctrl_if.slave    bus
);

    localparam int unsigned SLIP_W = $clog2(MAX_SLIP);

    align_state_e      state_r;
    align_state_e      next_state_s;
    logic [TMR_W-1:0]  tmr_r;
    logic              in_run_s;
    logic              run_start_s;
    logic              lock_s;

    logic              cken_r, cken_s;
    logic              align_ol_r, align_ol_s;
    logic              align_il_r, align_il_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              fail_r, fail_s;
    logic [SLIP_W-1:0] slip_cnt_r, slip_cnt_s;

    assign in_run_s    = (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_FAIL);
    assign run_start_s = !in_run_s && bus.start;

    ddrio_word_cmp #(.MATCH_CYC(MATCH_CYC)) u_word_cmp (
        .geclk_ol_buf_o (geclk_ol_buf_o),
        .align_rst_ol   (align_rst_ol),
        .en             (state_r == ST_CMP),
`ifdef DDRIO_ALIGN_ERRCNT_EN
        .clr            (run_start_s),
        .err_cnt        (bus.err_cnt),
`endif
        .pattern        (bus.pattern),
        .q_0            (bus.q_0),
        .q_1            (bus.q_1),
        .lock           (lock_s)
    );

    // State register.
    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Dwell timer for timed states and CMP window; restarts on every state change.
    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            tmr_r <= '0;
        end else if (next_state_s != state_r) begin
            tmr_r <= '0;
        end else if (in_run_s) begin
            tmr_r <= tmr_r + TMR_W'(1);
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.start) next_state_s = ST_SETTLE;
                else           next_state_s = state_r;
            end
            ST_SETTLE: begin
                if (tmr_r == TMR_W'(SETTLE_CYC - 32'd1)) next_state_s = ST_OL_PULSE;
                else                                      next_state_s = state_r;
            end
            ST_OL_PULSE: begin
                if (tmr_r == TMR_W'(PULSE_CYC - 32'd1)) next_state_s = ST_OL_WAIT;
                else                                     next_state_s = state_r;
            end
            ST_OL_WAIT, ST_SLIP_WAIT: begin
                if (tmr_r == TMR_W'(WAIT_CYC - 32'd1)) next_state_s = ST_CMP;
                else                                    next_state_s = state_r;
            end
            ST_CMP: begin
                // A lock on the last window cycle takes priority over the slip.
                if (lock_s) begin
                    next_state_s = ST_DONE;
                end else if (tmr_r == TMR_W'(CMP_WIN - 32'd1)) begin
                    if (slip_cnt_r == SLIP_W'(MAX_SLIP - 32'd1)) next_state_s = ST_FAIL;
                    else                                          next_state_s = ST_SLIP_PULSE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_SLIP_PULSE: begin
                if (tmr_r == TMR_W'(PULSE_CYC - 32'd1)) next_state_s = ST_SLIP_WAIT;
                else                                     next_state_s = state_r;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        cken_s     = cken_r || (next_state_s == ST_SETTLE);
        align_ol_s = (next_state_s == ST_OL_PULSE);
        align_il_s = (next_state_s == ST_SLIP_PULSE);
        busy_s     = (next_state_s != ST_IDLE) && (next_state_s != ST_DONE) &&
                     (next_state_s != ST_FAIL);
        done_s     = (next_state_s == ST_DONE);
        fail_s     = (next_state_s == ST_FAIL);
        if (run_start_s) begin
            slip_cnt_s = '0;
        end else if ((state_r == ST_CMP) && (next_state_s == ST_SLIP_PULSE)) begin
            slip_cnt_s = slip_cnt_r + SLIP_W'(1);
        end else begin
            slip_cnt_s = slip_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
        if (align_rst_ol) begin
            cken_r     <= 1'b0;
            align_ol_r <= 1'b0;
            align_il_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
            slip_cnt_r <= '0;
        end else begin
            cken_r     <= cken_s;
            align_ol_r <= align_ol_s;
            align_il_r <= align_il_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            fail_r     <= fail_s;
            slip_cnt_r <= slip_cnt_s;
        end
    end

    assign bus.cken     = cken_r;
    assign bus.align_ol = align_ol_r;
    assign bus.align_il = align_il_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.fail     = fail_r;
    assign bus.slip_cnt = slip_cnt_r;

endmodule

// File: tb/tb_ddrio_align_ctrl.sv
// Bench for ddrio_align_ctrl: a behavioural ddrio_x2 stand-in rotates the
// received words one bit per align_il pulse; expected timing comes from the
// sequence arithmetic (settle, pulse, wait, window, match lengths).
module tb_ddrio_align_ctrl;

    localparam int SETTLE = 16;
    localparam int PULSE  = 2;
    localparam int WAITC  = 8;
    localparam int MATCH  = 4;
    localparam int WIN    = 16;
    localparam int MAXS   = 8;
    localparam int FIRST_CMP = 1 + SETTLE + PULSE + WAITC;
    localparam int SLIP_PERIOD = WIN + PULSE + WAITC;
    localparam int FAIL_REL = FIRST_CMP + MAXS * WIN + (MAXS - 1) * (PULSE + WAITC);
    localparam int BUDGET = 400;

    logic geclk_ol_buf_o = 1'b0;
    logic align_rst_ol;

    ddrio_align_ctrl_if #(.SLIP_W(3)) bus ();

    ddrio_align_ctrl dut (
        .geclk_ol_buf_o (geclk_ol_buf_o),
        .align_rst_ol   (align_rst_ol),
        .bus            (bus)
    );

    always #5 geclk_ol_buf_o = ~geclk_ol_buf_o;

    int n_checks = 0;
    int n_fail   = 0;

    int rel, end_rel, rot, il_rise, il_high, ol_rise, ol_high, both_hit;
    logic       timed_out;
    logic [8:0] snap1, snap_pre, snap_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [15:0] d;
        d = {w, w} << (n % 8);
        return d[15:8];
    endfunction

    // {cken, align_ol, align_il, busy, done, fail, slip_cnt[2:0]}
    function automatic logic [8:0] outs();
        return {bus.cken, bus.align_ol, bus.align_il, bus.busy, bus.done, bus.fail, bus.slip_cnt};
    endfunction

    // One training run; raw words are what the PHY delivers at gear position 0.
    task automatic run(input logic [7:0] raw0, input logic [7:0] raw1,
                       input int glitch_rel, input int restart_rel, input int rst_rel);
        logic il_prev, ol_prev;
        bit   fin;
        rot = 0; il_rise = 0; il_high = 0; ol_rise = 0; ol_high = 0; both_hit = 0;
        timed_out = 1'b0; end_rel = -1; il_prev = 1'b0; ol_prev = 1'b0; fin = 1'b0;
        @(negedge geclk_ol_buf_o);
        bus.q_0 = rotl(raw0, 0);
        bus.q_1 = rotl(raw1, 0);
        bus.start = 1'b1;
        @(posedge geclk_ol_buf_o);
        rel = 1;
        while (!fin) begin
            @(negedge geclk_ol_buf_o);
            bus.start = (rel == restart_rel);
            if (rel == 1) snap1 = outs();
            if (bus.align_il && !il_prev) begin
                il_rise++;
                rot++;
            end
            if (bus.align_il) il_high++;
            if (bus.align_ol && !ol_prev) ol_rise++;
            if (bus.align_ol) ol_high++;
            il_prev = bus.align_il;
            ol_prev = bus.align_ol;
            if (bus.done && bus.fail) both_hit++;
            bus.q_0 = rotl(raw0, rot);
            bus.q_1 = (rel == glitch_rel) ? ~rotl(raw1, rot) : rotl(raw1, rot);
            if (rel == rst_rel) begin
                snap_pre = outs();
                #2 align_rst_ol = 1'b1;
                #1 snap_rst = outs();
                end_rel = rel;
                fin = 1'b1;
            end else if (bus.done || bus.fail) begin
                end_rel = rel;
                fin = 1'b1;
            end else if (rel >= BUDGET) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end else begin
                @(posedge geclk_ol_buf_o);
                rel++;
            end
        end
        bus.start = 1'b0;
    endtask

    // Common post-run checks for a run that should lock after k slips.
    task automatic chk_lock(input string tag, input int k, input int extra);
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        chk({tag, "_done_edge"}, end_rel, FIRST_CMP + k * SLIP_PERIOD + MATCH + extra);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_fail"}, 32'(bus.fail), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_slip_cnt"}, 32'(bus.slip_cnt), k);
        chk({tag, "_il_pulses"}, il_rise, k);
        chk({tag, "_il_cycles"}, il_high, k * PULSE);
        chk({tag, "_ol_pulses"}, ol_rise, 1);
        chk({tag, "_ol_cycles"}, ol_high, PULSE);
        chk({tag, "_start_snap"}, 32'(snap1), 32'h120);
    endtask

    task automatic chk_fail(input string tag);
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        chk({tag, "_fail_edge"}, end_rel, FAIL_REL);
        chk({tag, "_fail"}, 32'(bus.fail), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_slip_cnt"}, 32'(bus.slip_cnt), MAXS - 1);
        chk({tag, "_il_pulses"}, il_rise, MAXS - 1);
        chk({tag, "_il_cycles"}, il_high, (MAXS - 1) * PULSE);
        chk({tag, "_both"}, both_hit, 0);
        chk({tag, "_start_snap"}, 32'(snap1), 32'h120);
    endtask

    initial begin
        logic [7:0] p;
        int         k, bad, att;
        bit         ok;

        align_rst_ol = 1'b1;
        bus.start = 1'b0;
        bus.pattern = 8'hA5;
        bus.q_0 = 8'h00;
        bus.q_1 = 8'h00;
        repeat (3) @(negedge geclk_ol_buf_o);
        chk("reset_outs", 32'(outs()), 32'd0);
        align_rst_ol = 1'b0;
        repeat (3) @(negedge geclk_ol_buf_o);
        chk("idle_outs", 32'(outs()), 32'd0);

        // Word present from the start: lock at position 0.
        run(8'hA5, 8'hA5, -1, -1, -1);
        chk_lock("lock_pos0", 0, 0);
        chk("cken_held_done", 32'(bus.cken), 32'd1);

        // Correct word only after three slips; starts from DONE.
        run(rotl(8'hA5, 5), rotl(8'hA5, 5), -1, -1, -1);
        chk_lock("lock_pos3", 3, 0);

        // Restart from DONE clears slip_cnt; a start pulse while busy is ignored.
        run(8'hA5, 8'hA5, -1, 10, -1);
        chk_lock("busy_start_ignored", 0, 0);

        // Lane 1 never carries the word: all positions exhausted.
        run(8'hA5, 8'h00, -1, -1, -1);
        chk_fail("never_match");
        chk("cken_held_fail", 32'(bus.cken), 32'd1);
`ifdef DDRIO_ALIGN_ERRCNT_EN
        chk("err_cnt_fail", 32'(bus.err_cnt), MAXS * WIN);
`endif

        // Three matches, one mismatch, then four: lock waits for the full run of four.
        run(8'hA5, 8'hA5, FIRST_CMP + 3, -1, -1);
        chk_lock("match_break", 0, 4);
`ifdef DDRIO_ALIGN_ERRCNT_EN
        chk("err_cnt_break", 32'(bus.err_cnt), 32'd1);
`endif

        // Random patterns with distinct rotations and random slip targets.
        for (int i = 0; i < 9; i++) begin
            att = 0;
            ok = 1'b0;
            p = 8'hA5;
            while (!ok && att < 100) begin
                p = 8'($urandom);
                ok = 1'b1;
                for (int r = 1; r < 8; r++) if (rotl(p, r) == p) ok = 1'b0;
                att++;
            end
            if (!ok) p = 8'hA5;
            bus.pattern = p;
            k = int'($urandom_range(0, MAXS - 1));
            if (i % 3 == 2) begin
                run(8'h00, rotl(p, (8 - k) % 8), -1, -1, -1);
                chk_fail($sformatf("rand%0d_lane0_bad", i));
            end else begin
                run(rotl(p, (8 - k) % 8), rotl(p, (8 - k) % 8), -1, -1, -1);
                chk_lock($sformatf("rand%0d_k%0d", i, k), k, 0);
            end
        end

        // Reset in the middle of a compare window.
        bus.pattern = 8'hA5;
        run(8'hA5, 8'h00, -1, -1, 110);
        chk("rst_pre_slip", 32'(snap_pre[2:0]), (110 - (FIRST_CMP + WIN)) / SLIP_PERIOD + 1);
        chk("rst_pre_busy", 32'(snap_pre[5]), 32'd1);
        chk("rst_outs_now", 32'(snap_rst), 32'd0);
        repeat (3) @(negedge geclk_ol_buf_o);
        align_rst_ol = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge geclk_ol_buf_o);
            if (outs() != 9'd0) bad++;
        end
        chk("post_rst_idle", bad, 0);

        run(8'hA5, 8'hA5, -1, -1, -1);
        chk_lock("after_rst", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
